// File: rtl/ram8.sv
// ram8: 8-word x 16-bit register file with combinational read.
// Ports: CLK, RESET (async, active-high), IN[15:0], LOAD, ADDRESS[2:0], OUT[15:0].
module ram8 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] IN,
  input  logic        LOAD,
  input  logic [2:0]  ADDRESS,
  output logic [15:0] OUT
);

  logic [7:0]  w_we;
  logic [15:0] r_word [8];
  logic [15:0] w_rd;

  // One-hot demux of LOAD; all zero when LOAD is low.
  always_comb begin
    w_we = '0;
    if (LOAD) begin
      unique case (ADDRESS)
        3'd0: w_we = 8'b0000_0001;
        3'd1: w_we = 8'b0000_0010;
        3'd2: w_we = 8'b0000_0100;
        3'd3: w_we = 8'b0000_1000;
        3'd4: w_we = 8'b0001_0000;
        3'd5: w_we = 8'b0010_0000;
        3'd6: w_we = 8'b0100_0000;
        3'd7: w_we = 8'b1000_0000;
        default: w_we = '0;
      endcase
    end
  end

  // Each word is 16 enabled D cells; reset clears without a clock.
  for (genvar k = 0; k < 8; k++) begin : g_word
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        r_word[k] <= '0;
      end else if (w_we[k]) begin
        r_word[k] <= IN;
      end
    end
  end

  // Read mux: no bypass, so a write shows only after its edge.
  always_comb begin
    w_rd = '0;
    unique case (ADDRESS)
      3'd0: w_rd = r_word[0];
      3'd1: w_rd = r_word[1];
      3'd2: w_rd = r_word[2];
      3'd3: w_rd = r_word[3];
      3'd4: w_rd = r_word[4];
      3'd5: w_rd = r_word[5];
      3'd6: w_rd = r_word[6];
      3'd7: w_rd = r_word[7];
      default: w_rd = '0;
    endcase
  end

  assign OUT = w_rd;

endmodule

// File: tb/tb_ram8.sv
// tb_ram8: directed self-checking bench for ram8.
// Drives on negedge / #1 after posedge; checks with immediate assertions.
module tb_ram8;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        ld;
  logic [2:0]  addr;
  logic [15:0] dout;

  int vectors;
  int miscompares;

  ram8 dut (
    .CLK     (clk),
    .RESET   (rst),
    .IN      (din),
    .LOAD    (ld),
    .ADDRESS (addr),
    .OUT     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp,
                    input string tag);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    ld   = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    din  = 16'h0;
    ld   = 1'b0;
    addr = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, "rst_hold_out");

    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, "post_rst_sweep");

    // fill words with 1000+k; each write visible right after its edge
    for (int k = 0; k < 8; k++) begin
      wr(3'(k), 16'h1000 + 16'(k));
      chk("wr_latency", dout, 16'h1000 + 16'(k));
    end
    for (int k = 0; k < 8; k++) rd(3'(k), 16'h1000 + 16'(k), "fill_read");

    // read-during-write on word 3
    wr(3'd3, 16'hAAAA);
    @(negedge clk);
    addr = 3'd3;
    din  = 16'h5555;
    ld   = 1'b1;
    #1;
    chk("rdw_before", dout, 16'hAAAA);
    @(posedge clk);
    #1;
    ld = 1'b0;
    chk("rdw_after", dout, 16'h5555);
    rd(3'd4, 16'h1004, "rdw_neighbour");

    // IN toggling with LOAD low must not touch word 6
    addr = 3'd6;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      din = e[0] ? 16'h0000 : 16'hFFFF;
      #2 din = ~din;
      addr = 3'd2;
      #1 addr = 3'd6;
    end
    @(posedge clk);
    #1;
    rd(3'd6, 16'h1006, "hold_w6");
    rd(3'd2, 16'h1002, "hold_w2");

    // back-to-back same address
    wr(3'd7, 16'h0001);
    din = 16'h0002;
    ld  = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
    chk("b2b_same", dout, 16'h0002);
    rd(3'd6, 16'h1006, "b2b_other");

    // back-to-back different addresses
    wr(3'd0, 16'hC0DE);
    addr = 3'd1;
    din  = 16'hF00D;
    ld   = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
    rd(3'd0, 16'hC0DE, "b2b_diff0");
    rd(3'd1, 16'hF00D, "b2b_diff1");

    // fill with BEEF, then async reset between edges
    for (int k = 0; k < 8; k++) wr(3'(k), 16'hBEEF);
    rd(3'd5, 16'hBEEF, "beef_fill");
    @(negedge clk);
    addr = 3'd5;
    rst  = 1'b1;
    #1;
    chk("async_rst", dout, 16'h0000);

    // LOAD ignored during reset
    addr = 3'd4;
    din  = 16'h1234;
    ld   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, "rst_ld_ignored");

    // first write after reset release
    @(negedge clk);
    ld  = 1'b0;
    rst = 1'b0;
    wr(3'd4, 16'h1234);
    chk("first_wr", dout, 16'h1234);
    rd(3'd3, 16'h0000, "first_wr_other");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
